inst_fetch_unit: RTL and testbench
==================================

Name: inst_fetch_unit

Overview:
- Fetch stage directly upstream of the single-cycle control unit in the RV64I core.
- Holds the architectural PC and issues one request per instruction to instruction memory over a req/ack handshake.
- Latches the returned word and presents `inst` and `inst_opcode` to decode/control.
- Holds the instruction until control asserts `pc_write_en`, then loads `next_pc` and fetches again.
- Watchdog counter detects a hung memory.

Parameters:
- XLEN, 64, width of PC and address.
- RESET_VECTOR, 64'h0000_0000_0040_0000, PC value after reset.
- ACK_TIMEOUT, 16, maximum FETCH cycles without `imem_ack` before fault; legal range 1..255.

Ports:
- clock, input, 1, single core clock, rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- pc_write_en, input, 1, from control: current instruction done, advance PC.
- next_pc, input, XLEN, next PC from the branch/jump target logic.
- imem_req, output, 1, instruction memory request.
- imem_addr, output, XLEN, request address; equals `pc`.
- imem_ack, input, 1, memory has `imem_rdata` valid this cycle.
- imem_rdata, input, 32, fetched instruction word.
- pc, output, XLEN, address of the instruction in `inst`.
- inst, output, 32, latched instruction.
- inst_opcode, output, 7, `inst[6:0]`, feeds control `inst_opcode`.
- inst_valid, output, 1, `inst` is valid for execution.
- fetch_stall, output, 1, high whenever `inst_valid`=0; core must not commit.
- fetch_fault, output, 1, sticky fault flag.
- fault_cause, output, 2, 00 none, 01 ack timeout, 10 misaligned target.

Behaviour:
- Reset (async, any state):
  - pc=RESET_VECTOR; `imem_req`=0.
  - inst=32'h0000_0013 (NOP); inst_valid=0.
  - fetch_fault=0; fault_cause=00; wait counter=0; state=IDLE.
- Reset released mid-operation: always restarts from IDLE at RESET_VECTOR. Any ack arriving in IDLE is ignored.
- When inst_valid=0, inst_opcode=7'b0010011 (OP-IMM), so control produces benign, non-writing-to-memory signals.
- States IDLE, FETCH, EXEC, FAULT.
- IDLE:
  - Unconditionally moves to FETCH on the next edge.
- FETCH:
  - imem_req=1; imem_addr=pc, stable until ack.
  - Wait counter increments each cycle without ack.
  - On imem_ack: inst<=imem_rdata, inst_valid<=1, counter<=0, go to EXEC. imem_req drops on that edge.
  - Ack in the first FETCH cycle gives inst_valid on the following cycle (minimum latency 1 cycle from req to valid).
  - Counter reaching ACK_TIMEOUT without ack: fetch_fault<=1, fault_cause<=01, go to FAULT.
  - An ack on the same cycle the counter reaches ACK_TIMEOUT wins: no fault.
- EXEC:
  - imem_req=0; inst, pc held stable; inst_valid=1.
  - On pc_write_en: pc<=next_pc with bits [1:0] forced to 00, inst_valid<=0, go to FETCH.
  - imem_ack in EXEC is ignored.
- pc_write_en is ignored in IDLE, FETCH and FAULT.
- FAULT:
  - imem_req=0; inst_valid=0; pc frozen.
  - Only reset_n exits.
- PC arithmetic is pure load, no increment; `next_pc` wraps naturally at 2^XLEN.
- At most one outstanding request at any time.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- Defined: in EXEC with pc_write_en=1 and next_pc[1:0]!=00:
  - pc<=next_pc unmodified, inst_valid<=0.
  - fetch_fault<=1, fault_cause<=10, go to FAULT; no request issued.
- Undefined: next_pc[1:0] silently cleared, fault_cause value 10 never produced.

Test Plan:
1. Reset, then release; imem_ack one cycle after imem_req with imem_rdata=32'h0010_0093 -> imem_addr=64'h400000, inst_valid=1 the cycle after ack, inst_opcode=7'b0010011, pc=64'h400000.
2. In EXEC hold pc_write_en=0 for 5 cycles, then pulse it with next_pc=64'h400004 -> inst stable for the 5 cycles, no imem_req; then imem_req=1 with imem_addr=64'h400004 on the next cycle.
3. Never ack in FETCH (ACK_TIMEOUT=16) -> fetch_fault=1, fault_cause=01 after 16 cycles; imem_req=0; further pc_write_en/ack have no effect until reset_n=0.
4. Assert reset_n=0 mid-FETCH while ack is pending -> outputs return to reset values asynchronously; after release, first request goes to 64'h400000.
5. next_pc=64'h400102 with pc_write_en=1:
   - Without FETCH_MISALIGN_TRAP_EN -> next imem_addr=64'h400100.
   - With FETCH_MISALIGN_TRAP_EN -> fetch_fault=1, fault_cause=10, no imem_req.
6. imem_ack asserted while in EXEC -> inst unchanged, no state change.

Source files
------------

// File: rtl/inst_fetch_unit.sv
// -----------------------------------------------------------------------------
// inst_fetch_unit
//
// Fetch stage in front of the single-cycle RV64I control unit. It holds the
// architectural PC and issues one instruction-memory request per instruction
// over a req/ack handshake. It latches the returned word and holds it for
// decode/control until control signals completion with pc_write_en. Then it
// loads next_pc and fetches again. A watchdog faults the stage if memory never
// acknowledges a request.
//
// Optional feature (compile-time macro FETCH_MISALIGN_TRAP_EN):
//   defined   - a jump/branch to a target with next_pc[1:0] != 00 is trapped.
//               The stage enters FAULT with fault_cause = 2'b10.
//   undefined - next_pc[1:0] is silently cleared and fetch continues.
//
// Parameters:
//   XLEN         width of PC and address
//   RESET_VECTOR PC value after reset
//   ACK_TIMEOUT  FETCH cycles without imem_ack before fault (1..255)
//
// Ports:
//   clock        in   core clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   pc_write_en  in   control: current instruction done, advance PC
//   next_pc      in   next PC from branch/jump target logic
//   imem_req     out  instruction memory request
//   imem_addr    out  request address (equals pc)
//   imem_ack     in   imem_rdata valid this cycle
//   imem_rdata   in   fetched instruction word
//   pc           out  address of the instruction in inst
//   inst         out  latched instruction
//   inst_opcode  out  opcode for control (forced to OP-IMM while invalid)
//   inst_valid   out  inst is valid for execution
//   fetch_stall  out  high whenever inst_valid is low
//   fetch_fault  out  sticky fault flag
//   fault_cause  out  00 none, 01 ack timeout, 10 misaligned target
// -----------------------------------------------------------------------------
module inst_fetch_unit #(
  parameter int              XLEN         = 64,
  parameter logic [XLEN-1:0] RESET_VECTOR = 64'h0000_0000_0040_0000,
  parameter int              ACK_TIMEOUT  = 16
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            pc_write_en,
  input  logic [XLEN-1:0] next_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic [XLEN-1:0] pc,
  output logic [31:0]     inst,
  output logic [6:0]      inst_opcode,
  output logic            inst_valid,
  output logic            fetch_stall,
  output logic            fetch_fault,
  output logic [1:0]      fault_cause
);

  localparam logic [31:0] NOP_INST      = 32'h0000_0013;
  localparam logic [6:0]  OPCODE_OP_IMM = 7'b0010011;
  localparam logic [1:0]  CAUSE_NONE    = 2'b00;
  localparam logic [1:0]  CAUSE_TIMEOUT = 2'b01;
`ifdef FETCH_MISALIGN_TRAP_EN
  localparam logic [1:0]  CAUSE_MISALIGN = 2'b10;
`endif
  // The fault fires on the edge that ends the ACK_TIMEOUT-th waiting cycle.
  // At that point the counter still reads ACK_TIMEOUT-1.
  localparam logic [7:0]  WAIT_LAST     = 8'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    EXEC  = 2'b10,
    FAULT = 2'b11
  } state_t;

  state_t     state;
  logic [7:0] wait_cnt;

  // Word-align a target address by clearing its two low bits.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return addr & ~{{(XLEN-2){1'b0}}, 2'b11};
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      pc          <= RESET_VECTOR;
      imem_req    <= 1'b0;
      inst        <= NOP_INST;
      inst_valid  <= 1'b0;
      fetch_fault <= 1'b0;
      fault_cause <= CAUSE_NONE;
      wait_cnt    <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          // Any ack seen here belongs to a request from before reset. Drop it.
          state    <= FETCH;
          imem_req <= 1'b1;
          wait_cnt <= 8'd0;
        end

        FETCH: begin
          // An ack on the final watchdog cycle still wins over the timeout.
          if (imem_ack) begin
            inst       <= imem_rdata;
            inst_valid <= 1'b1;
            imem_req   <= 1'b0;
            wait_cnt   <= 8'd0;
            state      <= EXEC;
          end else if (wait_cnt == WAIT_LAST) begin
            fetch_fault <= 1'b1;
            fault_cause <= CAUSE_TIMEOUT;
            imem_req    <= 1'b0;
            state       <= FAULT;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        EXEC: begin
          if (pc_write_en) begin
            inst_valid <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (next_pc[1:0] != 2'b00) begin
              // Keep the offending target visible in pc for diagnosis.
              pc          <= next_pc;
              fetch_fault <= 1'b1;
              fault_cause <= CAUSE_MISALIGN;
              state       <= FAULT;
            end else begin
              pc       <= next_pc;
              imem_req <= 1'b1;
              wait_cnt <= 8'd0;
              state    <= FETCH;
            end
`else
            pc       <= align_pc(next_pc);
            imem_req <= 1'b1;
            wait_cnt <= 8'd0;
            state    <= FETCH;
`endif
          end
        end

        FAULT: begin
          // Sticky: only reset_n leaves this state.
          state <= FAULT;
        end

        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

  assign imem_addr   = pc;
  assign fetch_stall = ~inst_valid;
  // While nothing valid is held, control sees OP-IMM and produces benign signals.
  assign inst_opcode = inst_valid ? inst[6:0] : OPCODE_OP_IMM;

endmodule

// File: tb/tb_inst_fetch_unit.sv
module tb_inst_fetch_unit;

  localparam int          TMO = 16;
  localparam logic [63:0] RV  = 64'h0000_0000_0040_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef FETCH_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clock       = 1'b0;
  logic        reset_n     = 1'b1;
  logic        pc_write_en = 1'b0;
  logic [63:0] next_pc     = 64'd0;
  logic        imem_ack    = 1'b0;
  logic [31:0] imem_rdata  = 32'd0;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic [63:0] pc;
  logic [31:0] inst;
  logic [6:0]  inst_opcode;
  logic        inst_valid;
  logic        fetch_stall;
  logic        fetch_fault;
  logic [1:0]  fault_cause;

  inst_fetch_unit #(
    .XLEN        (64),
    .RESET_VECTOR(RV),
    .ACK_TIMEOUT (TMO)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .pc_write_en(pc_write_en),
    .next_pc    (next_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .pc         (pc),
    .inst       (inst),
    .inst_opcode(inst_opcode),
    .inst_valid (inst_valid),
    .fetch_stall(fetch_stall),
    .fetch_fault(fetch_fault),
    .fault_cause(fault_cause)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // Reference model. The instruction's situation is tracked as plain facts
  // (waiting for memory, holding a valid word, faulted) rather than as a state machine.
  logic [63:0] m_pc;
  logic [31:0] m_inst;
  bit          m_valid;
  bit          m_req;
  bit          m_fault;
  logic [1:0]  m_cause;
  int          m_wait;
  int          m_target;

  function automatic int pick_target();
    int r;
    r = $urandom_range(0, 19);
    if (r == 0) return 1000;
    if (r == 1) return TMO - 1;
    if (r == 2) return TMO - 2;
    return $urandom_range(0, 3);
  endfunction

  task automatic model_reset();
    m_pc = RV; m_inst = NOP; m_valid = 0; m_req = 0;
    m_fault = 0; m_cause = 2'd0; m_wait = 0; m_target = 0;
  endtask

  task automatic start_fetch();
    m_req = 1; m_wait = 0; m_target = pick_target();
  endtask

  task automatic model_step(input logic ack, input logic [31:0] rd,
                            input logic we, input logic [63:0] npc);
    if (m_fault) return;
    if (m_req) begin
      if (ack) begin
        m_inst = rd; m_valid = 1; m_req = 0;
      end else if (m_wait + 1 >= TMO) begin
        m_fault = 1; m_cause = 2'd1; m_req = 0;
      end else begin
        m_wait++;
      end
    end else if (m_valid) begin
      if (we) begin
        m_valid = 0;
        if (TRAP && (npc % 64'd4) != 64'd0) begin
          m_pc = npc; m_fault = 1; m_cause = 2'd2;
        end else begin
          m_pc = npc - (npc % 64'd4);
          start_fetch();
        end
      end
    end else begin
      start_fetch();
    end
  endtask

  task automatic check_all();
    check_eq("imem_req",    imem_req,    m_req);
    check_eq("imem_addr",   imem_addr,   m_pc);
    check_eq("pc",          pc,          m_pc);
    check_eq("inst",        inst,        m_inst);
    check_eq("inst_valid",  inst_valid,  m_valid);
    check_eq("inst_opcode", inst_opcode, m_valid ? m_inst[6:0] : 7'b0010011);
    check_eq("fetch_stall", fetch_stall, !m_valid);
    check_eq("fetch_fault", fetch_fault, m_fault);
    check_eq("fault_cause", fault_cause, m_cause);
  endtask

  // One clock cycle: drive, check at the falling edge, then advance the model at the rising edge.
  task automatic cyc(input logic ack, input logic [31:0] rd,
                     input logic we, input logic [63:0] npc);
    imem_ack = ack; imem_rdata = rd; pc_write_en = we; next_pc = npc;
    @(negedge clock);
    check_all();
    @(posedge clock);
    model_step(ack, rd, we, npc);
    #1;
  endtask

  // Asynchronous reset: outputs must go to reset values without a clock edge.
  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all();
    repeat (2) @(posedge clock);
    #1;
    check_all();
    reset_n = 1'b1;
  endtask

  int fault_cycles;

  initial begin
    logic        ack;
    logic        we;
    logic [63:0] npc;

    #2;
    do_reset();

    // Test 1: first fetch, ack one cycle after the request.
    cyc(1'b1, 32'hFFFF_FFFF, 1'b1, 64'h10);   // IDLE: ack and pc_write_en ignored
    check_eq("t1_req", imem_req, 1'b1);
    check_eq("t1_addr", imem_addr, 64'h400000);
    cyc(1'b0, 32'd0, 1'b0, 64'd0);
    cyc(1'b1, 32'h0010_0093, 1'b0, 64'd0);
    check_eq("t1_valid", inst_valid, 1'b1);
    check_eq("t1_opcode", inst_opcode, 7'b0010011);
    check_eq("t1_pc", pc, 64'h400000);
    check_eq("t1_inst", inst, 32'h0010_0093);

    // Test 2: hold in EXEC for five cycles, then advance.
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 32'd0, 1'b0, 64'd0);
      check_eq("t2_inst_hold", inst, 32'h0010_0093);
      check_eq("t2_no_req", imem_req, 1'b0);
    end
    cyc(1'b0, 32'd0, 1'b1, 64'h400004);
    check_eq("t2_req", imem_req, 1'b1);
    check_eq("t2_addr", imem_addr, 64'h400004);

    // Test 6: ack arriving in EXEC is ignored.
    cyc(1'b1, 32'h00A0_0513, 1'b0, 64'd0);
    cyc(1'b1, 32'hDEAD_BEEF, 1'b0, 64'd0);
    check_eq("t6_inst", inst, 32'h00A0_0513);
    check_eq("t6_valid", inst_valid, 1'b1);
    check_eq("t6_req", imem_req, 1'b0);

    // Test 5: misaligned jump target.
    cyc(1'b0, 32'd0, 1'b1, 64'h400102);
    if (TRAP) begin
      check_eq("t5_fault", fetch_fault, 1'b1);
      check_eq("t5_cause", fault_cause, 2'b10);
      check_eq("t5_req", imem_req, 1'b0);
    end else begin
      check_eq("t5_req", imem_req, 1'b1);
      check_eq("t5_addr", imem_addr, 64'h400100);
    end
    for (int i = 0; i < 3; i++) cyc(1'b0, 32'd0, 1'b0, 64'd0);
    do_reset();

    // Test 3: never acknowledge -> timeout fault, then sticky.
    cyc(1'b0, 32'd0, 1'b0, 64'd0);
    for (int i = 0; i < TMO; i++) cyc(1'b0, 32'd0, 1'b1, 64'h1234_5678);
    check_eq("t3_fault", fetch_fault, 1'b1);
    check_eq("t3_cause", fault_cause, 2'b01);
    check_eq("t3_req", imem_req, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b1, $urandom, 1'b1, {$urandom, $urandom});
    check_eq("t3_sticky", fault_cause, 2'b01);
    do_reset();

    // Boundary: ack on the final watchdog cycle wins over the timeout.
    cyc(1'b0, 32'd0, 1'b0, 64'd0);
    for (int i = 0; i < TMO - 1; i++) cyc(1'b0, 32'd0, 1'b0, 64'd0);
    cyc(1'b1, 32'h0000_0033, 1'b0, 64'd0);
    check_eq("edge_valid", inst_valid, 1'b1);
    check_eq("edge_nofault", fetch_fault, 1'b0);

    // Test 4: reset while a request is outstanding.
    cyc(1'b0, 32'd0, 1'b1, 64'h400200);
    cyc(1'b0, 32'd0, 1'b0, 64'd0);
    cyc(1'b0, 32'd0, 1'b0, 64'd0);
    do_reset();
    cyc(1'b1, 32'hFFFF_FFFF, 1'b0, 64'd0);
    check_eq("t4_addr", imem_addr, 64'h400000);
    check_eq("t4_req", imem_req, 1'b1);

    // Randomized operation against the model.
    fault_cycles = 0;
    for (int n = 0; n < 3000; n++) begin
      if (m_fault) fault_cycles++;
      else fault_cycles = 0;
      if (fault_cycles > 4) begin
        do_reset();
        fault_cycles = 0;
      end
      ack = m_req ? (m_wait == m_target) : ($urandom_range(0, 3) == 0);
      we  = m_valid ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) == 0);
      npc = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) npc[1:0] = 2'b00;
      cyc(ack, $urandom, we, npc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
